// File: rtl/seg7_pkg.sv
// Seven-segment constants shared by the display encoder and the scan decoder,
// plus the sampling FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic [1:0] {
        StIdle,
        StSettling,
        StSampled
    } state_e;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Combinational abcdefg pattern to BCD decoder; blank maps to BCD_BLANK,
// anything unrecognised to BCD_ERR with err set.
module seg7_pattern_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] val_o,
    output logic       err_o
);

    always_comb begin
        val_o = BCD_ERR;
        err_o = 1'b0;
        unique case (seg_i)
            SEG_0:     val_o = 4'd0;
            SEG_1:     val_o = 4'd1;
            SEG_2:     val_o = 4'd2;
            SEG_3:     val_o = 4'd3;
            SEG_4:     val_o = 4'd4;
            SEG_5:     val_o = 4'd5;
            SEG_6:     val_o = 4'd6;
            SEG_7:     val_o = 4'd7;
            SEG_8:     val_o = 4'd8;
            SEG_9:     val_o = 4'd9;
            SEG_BLANK: val_o = BCD_BLANK;
            default: begin
                val_o = BCD_ERR;
                err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers digit values from a multiplexed seven-segment bus: samples each
// strobed digit once it is stable, assembles full frames, presents them valid/ready.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned NDIG   = 4,
    parameter int unsigned SETTLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg,
    input  logic [NDIG-1:0]     dig_en,
    output logic [4*NDIG-1:0]   out_bcd,
    output logic [NDIG-1:0]     out_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                ovf
);

    localparam int unsigned      CntW      = $clog2(SETTLE + 1);
    localparam logic [CntW-1:0]  SettleCnt = CntW'(SETTLE);

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [NDIG+6:0]        last_q, last_d;
    logic [NDIG-1:0]        mask_q, mask_d;
    logic [4*NDIG-1:0]      store_bcd_q, store_bcd_d;
    logic [NDIG-1:0]        store_err_q, store_err_d;
    logic [4*NDIG-1:0]      out_bcd_q, out_bcd_d;
    logic [NDIG-1:0]        out_err_q, out_err_d;
    logic                   out_valid_q, out_valid_d;
    logic                   ovf_q, ovf_d;

    logic                   onehot;
    logic                   same;
    logic                   sample;
    logic [NDIG-1:0]        mask_set;
    logic [3:0]             dec_val;
    logic                   dec_err;

    seg7_pattern_dec u_dec (
        .seg_i (seg),
        .val_o (dec_val),
        .err_o (dec_err)
    );

    assign onehot = (dig_en != '0) && ((dig_en & (dig_en - NDIG'(1))) == '0);
    assign same   = ({dig_en, seg} == last_q);
    assign last_d = {dig_en, seg};

    // cnt counts consecutive identical cycles including the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sample  = 1'b0;
        if (!onehot) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else if (same && state_q == StSampled) begin
            state_d = StSampled;
        end else if (same && state_q == StSettling) begin
            if (cnt_q + CntW'(1) == SettleCnt) begin
                sample  = 1'b1;
                state_d = StSampled;
                cnt_d   = SettleCnt;
            end else begin
                state_d = StSettling;
                cnt_d   = cnt_q + CntW'(1);
            end
        end else begin
            cnt_d = CntW'(1);
            if (SettleCnt == CntW'(1)) begin
                sample  = 1'b1;
                state_d = StSampled;
            end else begin
                state_d = StSettling;
            end
        end
    end

    always_comb begin
        mask_d      = mask_q;
        store_bcd_d = store_bcd_q;
        store_err_d = store_err_q;
        out_bcd_d   = out_bcd_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        mask_set    = mask_q | dig_en;

        if (sample) begin
            for (int unsigned i = 0; i < NDIG; i++) begin
                if (dig_en[i]) begin
                    store_bcd_d[4*i +: 4] = dec_val;
                    store_err_d[i]        = dec_err;
                end
            end
            mask_d = mask_set;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // The completing digit is taken from the next-state store, not the flops.
        if (sample && mask_set == '1) begin
            mask_d = '0;
            if (!out_valid_q || out_ready) begin
                out_bcd_d   = store_bcd_d;
                out_err_d   = store_err_d;
                out_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            last_q      <= '0;
            mask_q      <= '0;
            store_bcd_q <= '0;
            store_err_q <= '0;
            out_bcd_q   <= '0;
            out_err_q   <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            mask_q      <= mask_d;
            store_bcd_q <= store_bcd_d;
            store_err_q <= store_err_d;
            out_bcd_q   <= out_bcd_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_bcd   = out_bcd_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the seven-segment path: watches a multiplexed display bus (one-hot digit strobe plus abcdefg segment lines) and recovers the digit values.
- Decodes each pattern back to BCD and assembles one value per full scan frame.
- Presents each frame on a valid/ready output.
- Used for display loop-back checking and for reading external scanned displays.

Parameters:
- NDIG, 4, number of multiplexed digits (>=1); digit i is selected by dig_en[i].
- SETTLE, 4, consecutive identical cycles of dig_en and seg required before a digit is sampled (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- seg  in  7  segment lines, bit6=a .. bit0=g, active-high; synchronous to clk (synchronisation is done upstream).
- dig_en  in  NDIG  digit strobe, active-high, one-hot while a digit is driven.
- out_bcd  out  4*NDIG  decoded frame; nibble i = digit i.
- out_err  out  NDIG  per-digit illegal-pattern flag for the held frame.
- out_valid  out  1  frame held in the output register.
- out_ready  in  1  consumer accepts the frame when out_valid&&out_ready.
- ovf  out  1  sticky; a completed frame was dropped.

Behaviour:
- Reset (rst=1 at a clk edge) clears everything in the block:
  - out_bcd=0, out_err=0, out_valid=0, ovf=0.
  - Capture mask, digit store, stability counter and last-input registers all cleared; FSM goes to IDLE.
  - Reset mid-frame discards the partial frame.
- Pattern decode (combinational sub-module), 7 bits -> {val[3:0], err}:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4.
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
  - 0000000 (blank) -> val=4'hF, err=0.
  - Any other pattern -> val=4'hE, err=1.
- Sampling FSM, states IDLE, SETTLING, SAMPLED:
  - IDLE: dig_en not one-hot (zero or more than one bit set); counter=0. A one-hot dig_en moves to SETTLING with counter=1.
  - SETTLING: each cycle where {dig_en,seg} equals the previous cycle's value, counter increments.
    - When the counter reaches SETTLE, that cycle is the sample cycle: the digit is stored at its end edge and the FSM moves to SAMPLED.
    - If dig_en or seg changes: restart SETTLING (counter=1) if the new dig_en is one-hot, else go to IDLE.
  - SETTLE=1: the first one-hot cycle is the sample cycle.
  - SAMPLED: no further sampling while inputs are unchanged. Any change leaves SAMPLED by the same rules as SETTLING.
  - Each dig_en assertion period yields exactly one sample.
- Frame assembly:
  - A sample of digit i writes nibble i and err bit i of the digit store and sets mask[i].
  - A re-sample of a digit already in the mask overwrites it; the latest value wins.
  - A frame is complete when a sample makes the mask all-ones. On that same edge:
    - Output free (!out_valid, or out_valid&&out_ready in that cycle): load out_bcd/out_err including the completing digit; out_valid=1 from the next cycle; clear the mask.
    - Output busy: drop the frame, set ovf=1, clear the mask; the output register is unchanged.
  - Latency: out_valid rises 1 cycle after the completing sample cycle, i.e. SETTLE cycles after the last digit's inputs settle.
- Handshake:
  - out_valid&&out_ready with no simultaneous load -> out_valid=0 next cycle.
  - out_bcd/out_err are stable while out_valid=1 and not accepted.
  - Accept and a new load in the same cycle -> the new frame loads and out_valid stays 1.
- ovf clears only on rst.

Decomposition:
- Package seg7_pkg:
  - Segment pattern constants SEG_0..SEG_9, SEG_BLANK.
  - Code constants BCD_BLANK=4'hF, BCD_ERR=4'hE.
  - FSM state enum typedef.
- These constants are shared with the existing encoder.
- One combinational sub-module, seg7_pattern_dec: seg[6:0] -> val[3:0], err.

Test Plan:
- NDIG=4, SETTLE=4, out_ready=1; scan digits 3..0 showing 1,2,3,4, each held 6 cycles -> out_bcd=16'h1234, out_err=0, out_valid high for 1 cycle, 4 cycles after digit 0 first appears.
- dig_en=0001 with seg toggling every 2 cycles, then held at 1111011 for 4 cycles -> exactly one sample, nibble0=9; no sample during toggling.
- Digit 2 driven with 1000001, others with 0/blank/5 -> out_bcd nibble2=4'hE, out_err=4'b0100; blank digit nibble=4'hF, its err bit=0.
- out_ready=0, complete two frames 16'h1111 then 16'h2222 -> output holds 16'h1111, ovf=1; raise out_ready -> accept, out_valid=0, ovf stays 1.
- dig_en=0011 for 10 cycles -> no sample, mask unchanged. Assert rst after 2 of 4 digits -> mask cleared, outputs 0; a fresh full scan then yields its own value only.
- Accept and a frame completion in the same cycle -> new frame loaded, out_valid stays 1, ovf=0.
